// File: rtl/piso_serializer_pkg.sv
//==============================================================================
// Module      : ser_pkg
// Description : Shared types and helpers for the parallel-in serial-out path.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_serializer.sv
//==============================================================================
// Module      : piso_serializer
// Description : WIDTH-bit word in over valid/ready, one bit per clock out with
//               frame valid / last-bit flags; words stream back-to-back.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             load_ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             x_last_o,
    output logic             busy_o
);

    localparam int                 c_cnt_w   = cnt_w(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_head;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_is_shift;
    logic               w_cnt_zero;
    logic               w_ready;

    // The output end of the register and the shift direction follow bit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head       = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head       = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_is_shift = (r_state == SHIFT);
    assign w_cnt_zero = (r_cnt == '0);

    // reset_n gates ready so nothing looks acceptable while reset is held.
    assign w_ready      = reset_n & (~w_is_shift | w_cnt_zero);
    assign load_ready_o = w_ready;
    assign x_o          = w_is_shift & w_head;
    assign x_valid_o    = w_is_shift;
    assign x_last_o     = w_is_shift & w_cnt_zero;
    assign busy_o       = w_is_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid_i) begin
                        r_shift <= load_data_i;
                        r_cnt   <= c_cnt_max;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!w_cnt_zero) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt - c_cnt_w'(1);
                    end else if (load_valid_i) begin
                        // Reload in the last-bit cycle keeps the stream gapless.
                        r_shift <= load_data_i;
                        r_cnt   <= c_cnt_max;
                    end else begin
                        r_shift <= w_shift_next;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
//==============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer (both bit orders).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_piso_serializer;
    import ser_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data  = '0;

    logic m_ready, m_x, m_v, m_last, m_busy;
    logic l_ready, l_x, l_v, l_last, l_busy;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(m_ready), .x_o(m_x), .x_valid_o(m_v), .x_last_o(m_last), .busy_o(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(l_ready), .x_o(l_x), .x_valid_o(l_v), .x_last_o(l_last), .busy_o(l_busy)
    );

    // Serial-in receivers (left shift) on each serial output.
    logic [W-1:0] rx_m = '0;
    logic [W-1:0] rx_l = '0;
    int           dut_hs = 0;
    always_ff @(posedge clk) begin
        rx_m <= {rx_m[W-2:0], m_x};
        rx_l <= {rx_l[W-2:0], l_x};
        if (load_valid && m_ready) dut_hs <= dut_hs + 1;
    end

    int checks = 0;
    int errors = 0;
    int model_hs = 0;

    // Reference: pending serial bits per bit order, their last flags, words in flight.
    bit           qm[$];
    bit           ql[$];
    bit           qlast[$];
    logic [W-1:0] words[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        bit v;
        v = (qm.size() != 0);
        chk({tag, "_m_valid"}, 32'(m_v),     32'(v));
        chk({tag, "_m_busy"},  32'(m_busy),  32'(v));
        chk({tag, "_m_x"},     32'(m_x),     32'(v ? qm[0] : 1'b0));
        chk({tag, "_m_last"},  32'(m_last),  32'(v ? qlast[0] : 1'b0));
        chk({tag, "_m_ready"}, 32'(m_ready), 32'(reset_n && qm.size() <= 1));
        chk({tag, "_l_valid"}, 32'(l_v),     32'(v));
        chk({tag, "_l_busy"},  32'(l_busy),  32'(v));
        chk({tag, "_l_x"},     32'(l_x),     32'(v ? ql[0] : 1'b0));
        chk({tag, "_l_last"},  32'(l_last),  32'(v ? qlast[0] : 1'b0));
        chk({tag, "_l_ready"}, 32'(l_ready), 32'(reset_n && qm.size() <= 1));
    endtask

    task automatic clear_model();
        qm.delete();
        ql.delete();
        qlast.delete();
        words.delete();
    endtask

    // Check the current cycle, advance one clock, update the model, then check loopback.
    task automatic tick(input string tag, output bit hs);
        bit           was_last;
        logic [W-1:0] w;
        check_outputs(tag);
        hs       = load_valid && reset_n && (qm.size() <= 1);
        was_last = (qm.size() != 0) && qlast[0];
        @(posedge clk);
        if (qm.size() != 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            void'(qlast.pop_front());
        end
        if (hs) begin
            model_hs++;
            words.push_back(load_data);
            for (int i = 0; i < W; i++) begin
                qm.push_back(load_data[W-1-i]);
                ql.push_back(load_data[i]);
                qlast.push_back(i == W - 1);
            end
        end
        #1;
        if (was_last) begin
            w = words.pop_front();
            chk({tag, "_rx_msb"}, 32'(rx_m), 32'(w));
            chk({tag, "_rx_lsb"}, 32'(rx_l), 32'(rev(w)));
        end
    endtask

    initial begin
        bit hs;
        int hs0;

        // Reset held with a word offered: nothing accepted, everything quiet.
        #2;
        reset_n    = 1'b0;
        load_valid = 1'b1;
        load_data  = 4'hF;
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        repeat (3) tick("rst_hold", hs);
        #2;
        load_valid = 1'b0;
        reset_n    = 1'b1;
        #1;
        check_outputs("rst_release");
        repeat (2) tick("rst_idle", hs);

        // Single word from IDLE.
        load_valid = 1'b1;
        load_data  = 4'hA;
        tick("t2_load", hs);
        load_valid = 1'b0;
        repeat (5) tick("t2_shift", hs);

        // Back-to-back: second word offered in the last-bit cycle.
        hs0        = dut_hs;
        load_valid = 1'b1;
        load_data  = 4'hA;
        tick("t3_load", hs);
        repeat (3) tick("t3_hold", hs);
        load_data = 4'h5;
        tick("t3_reload", hs);
        load_valid = 1'b0;
        repeat (5) tick("t3_shift", hs);
        chk("t3_handshakes", 32'(dut_hs - hs0), 32'd2);

        // Offer arrives mid-word: held off until the last-bit cycle.
        load_valid = 1'b1;
        load_data  = 4'h6;
        tick("t4_load", hs);
        load_valid = 1'b0;
        tick("t4_bit1", hs);
        load_valid = 1'b1;
        load_data  = 4'hF;
        hs = 1'b0;
        for (int k = 0; k < W + 2 && !hs; k++) tick("t4_wait", hs);
        load_valid = 1'b0;
        repeat (6) tick("t4_shift", hs);

        // Asynchronous reset mid-frame aborts the word.
        load_valid = 1'b1;
        load_data  = 4'hC;
        tick("t5_load", hs);
        load_valid = 1'b0;
        tick("t5_bit1", hs);
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        check_outputs("t5_abort");
        tick("t5_hold", hs);
        #2;
        reset_n = 1'b1;
        #1;
        check_outputs("t5_release");
        load_valid = 1'b1;
        load_data  = 4'h3;
        tick("t5_load3", hs);
        load_valid = 1'b0;
        repeat (5) tick("t5_shift", hs);

        // Random back-to-back stream with loopback reassembly.
        for (int n = 0; n < 32; n++) begin
            load_valid = 1'b1;
            load_data  = W'($urandom);
            hs = 1'b0;
            for (int k = 0; k < W + 2 && !hs; k++) tick("t6_stream", hs);
        end
        load_valid = 1'b0;
        repeat (W + 2) tick("t6_drain", hs);
        chk("hs_total", 32'(dut_hs), 32'(model_hs));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
